// File: rtl/instr_loader_pkg.sv
// Shared opcode/funct constants, descriptor kinds and the CPU control decode
// used by both the instruction loader and the core's control unit.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    K_LW   = 3'd0,
    K_SW   = 3'd1,
    K_BEQ  = 3'd2,
    K_ADDI = 3'd3,
    K_ADD  = 3'd4,
    K_SUB  = 3'd5,
    K_AND  = 3'd6,
    K_OR   = 3'd7
  } instr_kind_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } loader_state_e;

  // BEQ uses 1100111 because that is what our core's decoder treats as BEQ.
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100111;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SUB  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin c.reg_write = 1'b1; c.alu_op = 2'b10; end
      OP_LW:    begin
        c.reg_write = 1'b1; c.alu_src = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1;
      end
      OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BEQ:   begin c.branch = 1'b1; c.alu_op = 2'b01; end
      OP_ADDI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_loader_encoder.sv
// instr_encoder: combinational descriptor-to-instruction-word encoder,
// also reusable from testbenches.
module instr_encoder
  import instr_loader_pkg::*;
(
  input  instr_kind_e kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (kind)
      K_LW:   word = {imm, rs1, F3_LW, rd, OP_LW};
      K_SW:   word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_SW};
      // imm holds offset bits [12:1]: imm[11]=off[12], imm[10]=off[11]
      K_BEQ:  word = {imm[11], imm[9:4], rs2, rs1, F3_BEQ, imm[3:0], imm[10], OP_BEQ};
      K_ADDI: word = {imm, rs1, F3_ADDI, rd, OP_ADDI};
      K_ADD:  word = {F7_BASE, rs2, rs1, F3_ADD, rd, OP_RTYPE};
      K_SUB:  word = {F7_SUB, rs2, rs1, F3_SUB, rd, OP_RTYPE};
      K_AND:  word = {F7_BASE, rs2, rs1, F3_AND, rd, OP_RTYPE};
      K_OR:   word = {F7_BASE, rs2, rs1, F3_OR, rd, OP_RTYPE};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts instruction descriptors, encodes them and writes
// them to instruction memory at consecutive word addresses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start
// S_ACCEPT | in_ready high, waiting for a descriptor
// S_WRITE  | mem_we high for one cycle with encoded word
// S_FINISH | done pulse, then back to idle
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [2:0]  in_kind,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [11:0] in_imm,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  word_count
);

  loader_state_e state;
  logic          last_q;
  logic [31:0]   enc_word;
  logic [8:0]    count_next;
  logic          depth_hit;

  instr_encoder u_encoder (
    .kind (instr_kind_e'(in_kind)),
    .rd   (in_rd),
    .rs1  (in_rs1),
    .rs2  (in_rs2),
    .imm  (in_imm),
    .word (enc_word)
  );

  assign count_next = {1'b0, word_count} + 9'd1;
  assign depth_hit  = (count_next == 9'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
      last_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ACCEPT;
            in_ready   <= 1'b1;
            busy       <= 1'b1;
            word_count <= '0;
            overflow   <= 1'b0;
            mem_addr   <= BASE_ADDR;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            state     <= S_WRITE;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_wdata <= enc_word;
            last_q    <= in_last;
          end
        end
        S_WRITE: begin
          mem_we     <= 1'b0;
          mem_addr   <= mem_addr + 32'd4;
          word_count <= count_next[7:0];
          if (last_q || depth_hit) begin
            state <= S_FINISH;
            done  <= 1'b1;
            if (!last_q) overflow <= 1'b1;
          end else begin
            state    <= S_ACCEPT;
            in_ready <= 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: default instance (DEPTH 64, base 0) and
// a small instance (DEPTH 4, base 0x1000) for the overflow path.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, start4, in_valid, in_last;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [11:0] in_imm;

  logic        in_ready, mem_we, busy, done, overflow;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  word_count;
  logic        in_ready4, mem_we4, busy4, done4, overflow4;
  logic [31:0] mem_addr4, mem_wdata4;
  logic [7:0]  word_count4;

  int errors = 0;
  int checks = 0;

  logic [31:0] wa[$], wd[$], wa4[$], wd4[$];
  int n_done = 0, n_done4 = 0;

  always #5 clk = ~clk;

  instr_loader dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .overflow(overflow), .word_count(word_count)
  );

  instr_loader #(.BASE_ADDR(32'h0000_1000), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .in_valid(in_valid), .in_ready(in_ready4),
    .in_last(in_last), .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .busy(busy4), .done(done4), .overflow(overflow4), .word_count(word_count4)
  );

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin wa.push_back(mem_addr); wd.push_back(mem_wdata); end
    if (done === 1'b1) n_done++;
    if (mem_we4 === 1'b1) begin wa4.push_back(mem_addr4); wd4.push_back(mem_wdata4); end
    if (done4 === 1'b1) n_done4++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input instr_kind_e k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [11:0] imm, input logic last);
    in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
  endtask

  // Offers one descriptor from a negedge; returns on the negedge after acceptance.
  task automatic send(input bit sel, input instr_kind_e k, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [11:0] imm, input logic last);
    int n;
    drive(k, rd, rs1, rs2, imm, last);
    in_valid = 1'b1;
    n = 0;
    while ((sel ? in_ready4 : in_ready) !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready never rose for kind %0d", k);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel);
    int n;
    n = 0;
    while ((sel ? done4 : done) !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done pulse within 20 cycles");
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start4 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start4 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    checks++; if (word_count !== 8'd0) begin errors++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
    checks++; if (mem_addr4 !== 32'h1000) begin errors++; $display("FAIL rst_mem_addr4: got %h want 1000", mem_addr4); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int b, d;
    b = wa.size(); d = n_done;
    pulse_start(0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL single_accept: busy=%b in_ready=%b want 1 1", busy, in_ready); end
    send(0, K_ADDI, 5'd1, 5'd0, 5'd0, 12'd5, 1'b1);
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h00500093) begin errors++; $display("FAIL single_latency: mem_we=%b wdata=%h want 1 00500093", mem_we, mem_wdata); end
    wait_done(0);
    checks++; if (wa.size() - b !== 1) begin errors++; $display("FAIL single_nwrites: got %0d want 1", wa.size() - b); end
    else begin
      checks++; if (wa[b] !== 32'h0) begin errors++; $display("FAIL single_addr: got %h want 0", wa[b]); end
    end
    checks++; if (n_done - d !== 1) begin errors++; $display("FAIL single_done: got %0d pulses want 1", n_done - d); end
    checks++; if (word_count !== 8'd1) begin errors++; $display("FAIL single_count: got %0d want 1", word_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL single_overflow: got %b want 0", overflow); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_program();
    int b;
    logic [31:0] ea[3], ed[3];
    ea = '{32'h0, 32'h4, 32'h8};
    ed = '{32'h0080A103, 32'h0020A623, 32'h002081B3};
    b = wa.size();
    pulse_start(0);
    send(0, K_LW,  5'd2,  5'd1, 5'd0,  12'd8,  1'b0);
    send(0, K_SW,  5'd31, 5'd1, 5'd2,  12'd12, 1'b0);
    send(0, K_ADD, 5'd3,  5'd1, 5'd2,  12'hABC, 1'b1);
    wait_done(0);
    checks++; if (wa.size() - b !== 3) begin errors++; $display("FAIL prog_nwrites: got %0d want 3", wa.size() - b); end
    else for (int i = 0; i < 3; i++) begin
      checks++; if (wa[b+i] !== ea[i] || wd[b+i] !== ed[i]) begin
        errors++; $display("FAIL prog_word%0d: got %h@%h want %h@%h", i, wd[b+i], wa[b+i], ed[i], ea[i]);
      end
    end
    checks++; if (word_count !== 8'd3) begin errors++; $display("FAIL prog_count: got %0d want 3", word_count); end
  endtask

  task automatic test_beq();
    ctrl_t c;
    pulse_start(0);
    send(0, K_BEQ, 5'd7, 5'd1, 5'd2, 12'h004, 1'b1);
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h00208467) begin errors++; $display("FAIL beq_word: we=%b wdata=%h want 1 00208467", mem_we, mem_wdata); end
    c = decode_ctrl(mem_wdata[6:0]);
    checks++; if (c.branch !== 1'b1 || c.alu_op !== 2'b01) begin errors++; $display("FAIL beq_decode: branch=%b aluop=%b want 1 01", c.branch, c.alu_op); end
    wait_done(0);
  endtask

  task automatic test_stall_and_start();
    int b, d;
    b = wa.size(); d = n_done;
    pulse_start(0);
    send(0, K_SUB, 5'd4, 5'd5, 5'd6, 12'd0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h4 || word_count !== 8'd1) begin
        errors++; $display("FAIL stall_cycle%0d: rdy=%b we=%b addr=%h cnt=%0d want 1 0 4 1", i, in_ready, mem_we, mem_addr, word_count);
      end
      start = (i == 0);
      @(negedge clk);
    end
    start = 1'b0;
    send(0, K_OR, 5'd7, 5'd8, 5'd9, 12'd0, 1'b1);
    wait_done(0);
    checks++; if (wa.size() - b !== 2) begin errors++; $display("FAIL stall_nwrites: got %0d want 2", wa.size() - b); end
    else begin
      checks++; if (wa[b+1] !== 32'h4 || wd[b+1] !== 32'h009463B3) begin errors++; $display("FAIL stall_word1: got %h@%h want 009463b3@4", wd[b+1], wa[b+1]); end
      checks++; if (wd[b] !== 32'h406282B3 - 32'h00000080 + 32'h00000000) begin errors++; $display("FAIL stall_word0: got %h want 40628233", wd[b]); end
    end
    checks++; if (word_count !== 8'd2 || n_done - d !== 1) begin errors++; $display("FAIL stall_end: cnt=%0d done=%0d want 2 1", word_count, n_done - d); end
  endtask

  task automatic test_overflow();
    int b, d, acc, n;
    b = wa4.size(); d = n_done4; acc = 0;
    pulse_start(1);
    for (int k = 0; k < 6; k++) begin
      drive(K_ADDI, 5'(k + 1), 5'd0, 5'd0, 12'(k), 1'b0);
      in_valid = 1'b1;
      n = 0;
      while (in_ready4 !== 1'b1 && n < 6) begin @(negedge clk); n++; end
      if (in_ready4 === 1'b1) begin @(negedge clk); acc++; end
      in_valid = 1'b0;
    end
    checks++; if (acc !== 4) begin errors++; $display("FAIL ovf_accepted: got %0d want 4", acc); end
    checks++; if (wa4.size() - b !== 4) begin errors++; $display("FAIL ovf_nwrites: got %0d want 4", wa4.size() - b); end
    else begin
      checks++; if (wa4[b] !== 32'h1000 || wa4[b+3] !== 32'h100C) begin errors++; $display("FAIL ovf_addr: got %h..%h want 1000..100c", wa4[b], wa4[b+3]); end
      checks++; if (wd4[b+3] !== 32'h00300213) begin errors++; $display("FAIL ovf_word3: got %h want 00300213", wd4[b+3]); end
    end
    checks++; if (overflow4 !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow4); end
    checks++; if (n_done4 - d !== 1) begin errors++; $display("FAIL ovf_done: got %0d want 1", n_done4 - d); end
    checks++; if (in_ready4 !== 1'b0 || busy4 !== 1'b0 || word_count4 !== 8'd4) begin errors++; $display("FAIL ovf_end: rdy=%b busy=%b cnt=%0d want 0 0 4", in_ready4, busy4, word_count4); end
    pulse_start(1);
    checks++; if (overflow4 !== 1'b0 || word_count4 !== 8'd0 || mem_addr4 !== 32'h1000) begin
      errors++; $display("FAIL ovf_restart: ovf=%b cnt=%0d addr=%h want 0 0 1000", overflow4, word_count4, mem_addr4);
    end
    for (int k = 0; k < 4; k++) send(1, K_AND, 5'd1, 5'd2, 5'd3, 12'd0, logic'(k == 3));
    wait_done(1);
    checks++; if (overflow4 !== 1'b0 || word_count4 !== 8'd4) begin errors++; $display("FAIL ovf_exact_last: ovf=%b cnt=%0d want 0 4", overflow4, word_count4); end
  endtask

  task automatic test_reset_abort();
    int b, d;
    b = wa.size(); d = n_done;
    pulse_start(0);
    send(0, K_ADD, 5'd1, 5'd1, 5'd1, 12'd0, 1'b0);
    send(0, K_ADD, 5'd2, 5'd2, 5'd2, 12'd0, 1'b0);
    @(negedge clk);
    drive(K_ADD, 5'd3, 5'd3, 5'd3, 12'd0, 1'b0);
    reset = 1'b1; in_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || word_count !== 8'd0) begin
      errors++; $display("FAIL abort_state: busy=%b rdy=%b we=%b addr=%h cnt=%0d want 0 0 0 0 0", busy, in_ready, mem_we, mem_addr, word_count);
    end
    reset = 1'b0; in_valid = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (wa.size() - b !== 2) begin errors++; $display("FAIL abort_nwrites: got %0d want 2", wa.size() - b); end
    checks++; if (n_done - d !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_done: done=%0d busy=%b want 0 0", n_done - d, busy); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start4 = 1'b0; in_valid = 1'b0;
    drive(K_LW, 5'd0, 5'd0, 5'd0, 12'd0, 1'b0);
    @(negedge clk);
    test_reset();
    test_single();
    test_program();
    test_beq();
    test_stall_and_start();
    test_overflow();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
